// File: rtl/intr_arbiter_if.sv
// Bundle between the IRQ front-end arbiter and its surroundings: board IRQ
// lines, mask register access, and the handshake with the interrupt unit.
interface intr_arbiter_if #(
  parameter int N_IRQ = 4
);
  localparam int ID_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  logic [N_IRQ-1:0] irq_in;
  logic             mask_we;
  logic [N_IRQ-1:0] mask_wdata;
  logic             exe_intr;
  logic             ints_end;
  logic             ext_intr;
  logic [ID_W-1:0]  irq_id;
  logic [31:0]      int_vector;
  logic [N_IRQ-1:0] pending;
  logic [N_IRQ-1:0] mask;
  logic             in_service;

  // The arbiter itself: consumes IRQs / handshake, drives the request side.
  modport slave (
    input  irq_in, mask_we, mask_wdata, exe_intr, ints_end,
    output ext_intr, irq_id, int_vector, pending, mask, in_service
  );

  // Whoever drives the pins and plays the interrupt unit.
  modport master (
    output irq_in, mask_we, mask_wdata, exe_intr, ints_end,
    input  ext_intr, irq_id, int_vector, pending, mask, in_service
  );
endinterface

// File: rtl/intr_arbiter.sv
// IRQ front-end: edge capture, software mask, fixed or round-robin winner
// selection and a single-cycle request to the interrupt unit, held off until
// that unit finishes servicing.
//
//  state    | meaning
//  ---------+----------------------------------------------------------
//  IDLE     | waiting for an eligible request while the unit is not busy
//  ISSUE    | ext_intr pulse high, winner already latched
//  WAIT_ACK | waiting for exe_intr; down-counter times out and re-pends
//  SERVICE  | unit is servicing; leave on ints_end or exe_intr falling
module intr_arbiter #(
  parameter int              N_IRQ       = 4,
  parameter int              PRIORITY_RR = 0,
  parameter logic [31:0]     VEC_BASE    = 32'h0000_0200,
  parameter logic [31:0]     VEC_STRIDE  = 32'h0000_0020,
  parameter int              ACK_TIMEOUT = 8,
  parameter logic [N_IRQ-1:0] MASK_RST   = '0
) (
  input logic          clk,
  input logic          rst,
  intr_arbiter_if.slave bus
);

  localparam int ID_W  = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;
  localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [N_IRQ-1:0] ONE_HOT0 = {{(N_IRQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, SERVICE} state_t;

  state_t           state_q, state_d;
  logic [N_IRQ-1:0] irq_q, irq_d;
  logic [N_IRQ-1:0] pending_q, pending_d;
  logic [N_IRQ-1:0] mask_q, mask_d;
  logic             ext_intr_q, ext_intr_d;
  logic [ID_W-1:0]  irq_id_q, irq_id_d;
  logic [31:0]      vec_q, vec_d;
  logic             in_service_q, in_service_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] eligible;
  logic             win_found;
  logic [ID_W-1:0]  win_id;
  logic [ID_W:0]    rr_sum;
  logic [ID_W-1:0]  rr_next;
  logic [31:0]      win_vec;
  logic [N_IRQ-1:0] win_oh;
  logic [N_IRQ-1:0] issue_clr;
  logic [N_IRQ-1:0] timeout_set;

  // Winner selection over unmasked pending requests.
  always_comb begin
    rise      = bus.irq_in & ~irq_q;
    eligible  = pending_q & ~mask_q;
    win_found = 1'b0;
    win_id    = '0;
    rr_sum    = '0;
    if (PRIORITY_RR != 0) begin
      // Scan from rr_ptr upward with wrap; first hit wins.
      for (int k = 0; k < N_IRQ; k++) begin
        rr_sum = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
        if (rr_sum >= (ID_W+1)'(N_IRQ)) rr_sum = rr_sum - (ID_W+1)'(N_IRQ);
        if (!win_found && eligible[rr_sum[ID_W-1:0]]) begin
          win_found = 1'b1;
          win_id    = rr_sum[ID_W-1:0];
        end
      end
    end else begin
      // Walking down leaves the lowest eligible index as the winner.
      for (int i = N_IRQ - 1; i >= 0; i--) begin
        if (eligible[i[ID_W-1:0]]) begin
          win_found = 1'b1;
          win_id    = i[ID_W-1:0];
        end
      end
    end
    rr_next = (win_id == ID_W'(N_IRQ - 1)) ? '0 : win_id + 1'b1;
    win_vec = VEC_BASE + VEC_STRIDE * 32'(win_id);
    win_oh  = ONE_HOT0 << win_id;
  end

  // Next-state and registered-output computation. Outputs belonging to a
  // state are computed on entry so they are visible during that state.
  always_comb begin
    state_d      = state_q;
    irq_d        = bus.irq_in;
    mask_d       = bus.mask_we ? bus.mask_wdata : mask_q;
    ext_intr_d   = 1'b0;
    irq_id_d     = irq_id_q;
    vec_d        = vec_q;
    in_service_d = in_service_q;
    rr_ptr_d     = rr_ptr_q;
    cnt_d        = cnt_q;
    issue_clr    = '0;
    timeout_set  = '0;
    case (state_q)
      IDLE: begin
        if (win_found && !bus.exe_intr) begin
          state_d      = ISSUE;
          ext_intr_d   = 1'b1;
          irq_id_d     = win_id;
          vec_d        = win_vec;
          in_service_d = 1'b1;
          issue_clr    = win_oh;
          if (PRIORITY_RR != 0) rr_ptr_d = rr_next;
        end
      end
      ISSUE: begin
        state_d = WAIT_ACK;
        cnt_d   = CNT_LOAD;
      end
      WAIT_ACK: begin
        if (bus.exe_intr) begin
          state_d = SERVICE;
        end else if (cnt_q == '0) begin
          // Unit never took it: put the request back for another try.
          state_d      = IDLE;
          timeout_set  = ONE_HOT0 << irq_id_q;
          in_service_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      SERVICE: begin
        // Entry required exe_intr high, so seeing it low here is its fall.
        if (bus.ints_end || !bus.exe_intr) begin
          state_d      = IDLE;
          in_service_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    // A fresh edge on the line being cleared survives.
    pending_d = (pending_q & ~issue_clr) | timeout_set | rise;
  end

  // Single register bank for the FSM, edge detector, mask and outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      irq_q        <= '0;
      pending_q    <= '0;
      mask_q       <= MASK_RST;
      ext_intr_q   <= 1'b0;
      irq_id_q     <= '0;
      vec_q        <= VEC_BASE;
      in_service_q <= 1'b0;
      rr_ptr_q     <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      irq_q        <= irq_d;
      pending_q    <= pending_d;
      mask_q       <= mask_d;
      ext_intr_q   <= ext_intr_d;
      irq_id_q     <= irq_id_d;
      vec_q        <= vec_d;
      in_service_q <= in_service_d;
      rr_ptr_q     <= rr_ptr_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bus.ext_intr   = ext_intr_q;
  assign bus.irq_id     = irq_id_q;
  assign bus.int_vector = vec_q;
  assign bus.pending    = pending_q;
  assign bus.mask       = mask_q;
  assign bus.in_service = in_service_q;

endmodule

// File: tb/tb_intr_arbiter.sv
// Directed bench for intr_arbiter: a fixed-priority instance for most
// scenarios and a round-robin instance for issue-order rotation.
module tb_intr_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  intr_arbiter_if #(.N_IRQ(4)) bus_f ();
  intr_arbiter_if #(.N_IRQ(4)) bus_r ();

  intr_arbiter #(.N_IRQ(4), .PRIORITY_RR(0)) u_fix (.clk(clk), .rst(rst), .bus(bus_f));
  intr_arbiter #(.N_IRQ(4), .PRIORITY_RR(1)) u_rr  (.clk(clk), .rst(rst), .bus(bus_r));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Outputs are sampled and inputs driven 1 ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Called in the WAIT_ACK cycle: acknowledge, then end service.
  task automatic service_f(input string tag);
    bus_f.exe_intr = 1'b1;
    tick();
    check({tag, "_svc_busy"}, 32'(bus_f.in_service), 32'd1);
    bus_f.ints_end = 1'b1;
    tick();
    bus_f.exe_intr = 1'b0;
    bus_f.ints_end = 1'b0;
    check({tag, "_svc_done"}, 32'(bus_f.in_service), 32'd0);
  endtask

  int exp_ids [5] = '{0, 1, 2, 3, 0};
  bit seen;

  initial begin
    bus_f.irq_in = '0; bus_f.mask_we = 1'b0; bus_f.mask_wdata = '0;
    bus_f.exe_intr = 1'b0; bus_f.ints_end = 1'b0;
    bus_r.irq_in = '0; bus_r.mask_we = 1'b0; bus_r.mask_wdata = '0;
    bus_r.exe_intr = 1'b0; bus_r.ints_end = 1'b0;

    // reset values
    rst = 1'b1;
    tick(); tick();
    check("rst_ext",     32'(bus_f.ext_intr),   32'd0);
    check("rst_id",      32'(bus_f.irq_id),     32'd0);
    check("rst_vec",     bus_f.int_vector,      32'h0000_0200);
    check("rst_pend",    32'(bus_f.pending),    32'd0);
    check("rst_mask",    32'(bus_f.mask),       32'd0);
    check("rst_insvc",   32'(bus_f.in_service), 32'd0);
    rst = 1'b0;
    tick();

    // T1 single source
    bus_f.irq_in = 4'b0100;
    tick();
    check("t1_pend",     32'(bus_f.pending),    32'h4);
    check("t1_ext_early",32'(bus_f.ext_intr),   32'd0);
    tick();
    check("t1_ext",      32'(bus_f.ext_intr),   32'd1);
    check("t1_id",       32'(bus_f.irq_id),     32'd2);
    check("t1_vec",      bus_f.int_vector,      32'h0000_0240);
    tick();
    check("t1_pend_clr", 32'(bus_f.pending),    32'd0);
    check("t1_pulse",    32'(bus_f.ext_intr),   32'd0);
    check("t1_insvc",    32'(bus_f.in_service), 32'd1);
    service_f("t1");
    bus_f.irq_in = 4'b0000;

    // T2 fixed priority
    bus_f.irq_in = 4'b1010;
    tick(); tick();
    check("t2_ext_a",    32'(bus_f.ext_intr),   32'd1);
    check("t2_id_a",     32'(bus_f.irq_id),     32'd1);
    check("t2_vec_a",    bus_f.int_vector,      32'h0000_0220);
    tick();
    check("t2_pend",     32'(bus_f.pending),    32'h8);
    service_f("t2a");
    tick();
    check("t2_ext_b",    32'(bus_f.ext_intr),   32'd1);
    check("t2_id_b",     32'(bus_f.irq_id),     32'd3);
    check("t2_vec_b",    bus_f.int_vector,      32'h0000_0260);
    tick();
    service_f("t2b");
    bus_f.irq_in = 4'b0000;

    // T4 mask
    bus_f.mask_we = 1'b1; bus_f.mask_wdata = 4'b0001;
    tick();
    bus_f.mask_we = 1'b0;
    check("t4_mask_set", 32'(bus_f.mask),       32'h1);
    bus_f.irq_in = 4'b0001;
    tick();
    check("t4_pend",     32'(bus_f.pending),    32'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4_masked_ext", 32'(bus_f.ext_intr), 32'd0);
    end
    check("t4_pend_kept",32'(bus_f.pending),    32'h1);
    bus_f.mask_we = 1'b1; bus_f.mask_wdata = 4'b0000;
    tick();
    bus_f.mask_we = 1'b0;
    check("t4_mask_clr", 32'(bus_f.mask),       32'h0);
    check("t4_ext_early",32'(bus_f.ext_intr),   32'd0);
    tick();
    check("t4_ext",      32'(bus_f.ext_intr),   32'd1);
    check("t4_id",       32'(bus_f.irq_id),     32'd0);
    check("t4_vec",      bus_f.int_vector,      32'h0000_0200);
    tick();
    service_f("t4");
    bus_f.irq_in = 4'b0000;

    // T5 acknowledge timeout, with a stray ints_end that must be ignored
    bus_f.irq_in = 4'b0100;
    tick(); tick();
    check("t5_ext",      32'(bus_f.ext_intr),   32'd1);
    check("t5_id",       32'(bus_f.irq_id),     32'd2);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("t5_wait_ext",   32'(bus_f.ext_intr),   32'd0);
      check("t5_wait_insvc", 32'(bus_f.in_service), 32'd1);
      if (i == 7) check("t5_wait_pend", 32'(bus_f.pending), 32'd0);
      bus_f.ints_end = (i == 2);
    end
    tick();
    check("t5_repend",   32'(bus_f.pending),    32'h4);
    check("t5_to_insvc", 32'(bus_f.in_service), 32'd0);
    check("t5_to_ext",   32'(bus_f.ext_intr),   32'd0);
    tick();
    check("t5_reissue",  32'(bus_f.ext_intr),   32'd1);
    check("t5_reid",     32'(bus_f.irq_id),     32'd2);
    tick();
    service_f("t5");
    bus_f.irq_in = 4'b0000;

    // T6 blocking by exe_intr, then reset during SERVICE
    bus_f.exe_intr = 1'b1;
    bus_f.irq_in   = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t6_blocked",  32'(bus_f.ext_intr), 32'd0);
    end
    check("t6_pend",     32'(bus_f.pending),    32'h2);
    bus_f.exe_intr = 1'b0;
    tick();
    check("t6_ext",      32'(bus_f.ext_intr),   32'd1);
    check("t6_id",       32'(bus_f.irq_id),     32'd1);
    tick();
    bus_f.exe_intr = 1'b1;
    tick();
    check("t6_svc",      32'(bus_f.in_service), 32'd1);
    bus_f.irq_in     = 4'b1010;
    bus_f.mask_we    = 1'b1;
    bus_f.mask_wdata = 4'b0100;
    tick();
    bus_f.mask_we = 1'b0;
    check("t6_accum",    32'(bus_f.pending),    32'h8);
    check("t6_no_nest",  32'(bus_f.ext_intr),   32'd0);
    check("t6_mask",     32'(bus_f.mask),       32'h4);
    rst = 1'b1;
    bus_f.exe_intr = 1'b0;
    tick();
    check("t6r_ext",     32'(bus_f.ext_intr),   32'd0);
    check("t6r_id",      32'(bus_f.irq_id),     32'd0);
    check("t6r_vec",     bus_f.int_vector,      32'h0000_0200);
    check("t6r_pend",    32'(bus_f.pending),    32'd0);
    check("t6r_mask",    32'(bus_f.mask),       32'd0);
    check("t6r_insvc",   32'(bus_f.in_service), 32'd0);
    rst = 1'b0;
    tick();
    check("t6_held_edge",32'(bus_f.pending),    32'hA);
    rst = 1'b1;
    tick();
    check("t6_suppress", 32'(bus_f.ext_intr),   32'd0);
    check("t6_sup_pend", 32'(bus_f.pending),    32'd0);
    bus_f.irq_in = 4'b0000;
    rst = 1'b0;
    tick();

    // T3 round robin: every serviced line re-raised, so all stay pending
    bus_r.irq_in = 4'b1111;
    tick();
    check("t3_pend",     32'(bus_r.pending),    32'hF);
    tick();
    for (int k = 0; k < 5; k++) begin
      seen = 1'b0;
      for (int c = 0; c < 6 && !seen; c++) begin
        if (bus_r.ext_intr) seen = 1'b1;
        else tick();
      end
      check("t3_seen",   32'(seen),             32'd1);
      check("t3_id",     32'(bus_r.irq_id),     32'(exp_ids[k]));
      check("t3_vec",    bus_r.int_vector,      32'h0000_0200 + 32'h20 * 32'(exp_ids[k]));
      tick();
      bus_r.exe_intr = 1'b1;
      bus_r.irq_in[exp_ids[k]] = 1'b0;
      tick();
      bus_r.irq_in[exp_ids[k]] = 1'b1;
      bus_r.ints_end = 1'b1;
      tick();
      bus_r.exe_intr = 1'b0;
      bus_r.ints_end = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
